// File: rtl/seq_tx_pkg.sv
// Shared types and helpers for the serial frame transmitter.
// Parity support in seq_frame_tx is selected by the PARITY_EN macro.
package seq_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_DATA = 3'd2,
        ST_PAR  = 3'd3,
        ST_GAP  = 3'd4
    } state_e;

    localparam logic [3:0] DEFAULT_PREAMBLE = 4'b1011;

    // Bits needed to hold values 0..value-1, never less than one.
    function automatic int clog2(input int value);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/seq_tx_shifter.sv
// MSB-first shift register with a remaining-bits down-counter.
// load presents the MSB immediately to the caller and keeps only the rest.
module seq_tx_shifter
    import seq_tx_pkg::*;
#(
    parameter int W     = 12,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [W-1:0]     load_data,
    input  logic             set_cnt,
    input  logic [CNT_W-1:0] cnt_in,
    input  logic             shift,
    output logic             bit_out,
    output logic             last,
    output logic             almost_last
);

    logic [W-1:0]     data_q, data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        data_d = data_q;
        cnt_d  = cnt_q;
        if (load) begin
            data_d = load_data << 1;
            cnt_d  = cnt_in;
        end else begin
            if (shift) data_d = data_q << 1;
            // Counter saturates at zero so it never wraps.
            if (set_cnt)
                cnt_d = cnt_in;
            else if (shift && cnt_q != '0)
                cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_q <= '0;
            cnt_q  <= '0;
        end else begin
            data_q <= data_d;
            cnt_q  <= cnt_d;
        end
    end

    assign bit_out     = data_q[W-1];
    assign last        = (cnt_q == '0);
    assign almost_last = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/seq_frame_tx.sv
// Serial frame transmitter: preamble, payload MSB first, optional parity, idle gap.
// Define PARITY_EN to append an even-parity bit after the payload.
module seq_frame_tx
    import seq_tx_pkg::*;
#(
    parameter int               DATA_W     = 8,
    parameter int               PRE_W      = 4,
    parameter logic [PRE_W-1:0] PREAMBLE   = PRE_W'(DEFAULT_PREAMBLE),
    parameter int               GAP_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              x,
    output logic              x_valid,
    output logic              busy,
    output logic              done
);

    localparam int FRAME_W = PRE_W + DATA_W;
    localparam int CNT_W   = clog2(max3(PRE_W, DATA_W, GAP_CYCLES) + 1);
    localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(PRE_W - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_e state_q, state_d;
    logic   x_q, x_d, x_valid_q, x_valid_d, done_q, done_d;
    logic   sh_load, sh_set_cnt, sh_shift, sh_bit, sh_last, sh_almost_last;
    logic   frame_end;
    logic   [CNT_W-1:0] sh_cnt_in;
`ifdef PARITY_EN
    logic   parity_q, parity_d;
`endif

    seq_tx_shifter #(.W(FRAME_W), .CNT_W(CNT_W)) u_shifter (
        .clk         (clk),
        .reset       (reset),
        .load        (sh_load),
        .load_data   ({PREAMBLE, in_data}),
        .set_cnt     (sh_set_cnt),
        .cnt_in      (sh_cnt_in),
        .shift       (sh_shift),
        .bit_out     (sh_bit),
        .last        (sh_last),
        .almost_last (sh_almost_last)
    );

    assign in_ready = (state_q == ST_IDLE);
    assign busy     = (state_q != ST_IDLE);

    // x_d is the bit shown in the cycle after this edge, so each branch
    // computes the bit belonging to state_d.
    always_comb begin
        state_d    = state_q;
        x_d        = 1'b0;
        x_valid_d  = 1'b0;
        done_d     = 1'b0;
        sh_load    = 1'b0;
        sh_set_cnt = 1'b0;
        sh_shift   = 1'b0;
        sh_cnt_in  = '0;
        frame_end  = 1'b0;
`ifdef PARITY_EN
        parity_d   = parity_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    state_d   = ST_PRE;
                    sh_load   = 1'b1;
                    sh_cnt_in = PRE_LAST;
                    x_d       = PREAMBLE[PRE_W-1];
                    x_valid_d = 1'b1;
`ifdef PARITY_EN
                    parity_d  = ^in_data;
`endif
                end
            end
            ST_PRE: begin
                sh_shift  = 1'b1;
                x_d       = sh_bit;
                x_valid_d = 1'b1;
                if (sh_last) begin
                    state_d    = ST_DATA;
                    sh_set_cnt = 1'b1;
                    sh_cnt_in  = DATA_LAST;
                end
            end
            ST_DATA: begin
                if (!sh_last) begin
                    sh_shift  = 1'b1;
                    x_d       = sh_bit;
                    x_valid_d = 1'b1;
                end else begin
`ifdef PARITY_EN
                    state_d   = ST_PAR;
                    x_d       = parity_q;
                    x_valid_d = 1'b1;
`else
                    frame_end = 1'b1;
`endif
                end
            end
`ifdef PARITY_EN
            ST_PAR:  frame_end = 1'b1;
`endif
            ST_GAP: begin
                if (sh_last) state_d = ST_IDLE;
                else         sh_shift = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase

        if (frame_end) begin
            if (GAP_CYCLES > 0) begin
                state_d    = ST_GAP;
                sh_set_cnt = 1'b1;
                sh_cnt_in  = GAP_LAST;
            end else begin
                state_d = ST_IDLE;
            end
        end

        // done rides with the final frame bit, which is entered on this edge.
`ifdef PARITY_EN
        done_d = (state_d == ST_PAR);
`else
        if (state_d == ST_DATA)
            done_d = (state_q == ST_PRE) ? (DATA_W == 1) : sh_almost_last;
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            x_q       <= 1'b0;
            x_valid_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            x_valid_q <= x_valid_d;
            done_q    <= done_d;
        end
    end

`ifdef PARITY_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) parity_q <= 1'b0;
        else        parity_q <= parity_d;
    end
`endif

    assign x       = x_q;
    assign x_valid = x_valid_q;
    assign done    = done_q;

endmodule

// File: tb/tb_seq_frame_tx.sv
// Directed bench for seq_frame_tx: one instance with a 1-cycle gap, one with no gap.
module tb_seq_frame_tx;
    import seq_tx_pkg::*;

    localparam int PRE_W = 4;
`ifdef PARITY_EN
    localparam int FL = 13;
`else
    localparam int FL = 12;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic a_valid = 1'b0, b_valid = 1'b0;
    logic [7:0] a_data = 8'h00, b_data = 8'h00;
    logic a_ready, a_x, a_xv, a_busy, a_done;
    logic b_ready, b_x, b_xv, b_busy, b_done;

    int total = 0;
    int bad = 0;
    int z_pos[$];

    always #5 clk = ~clk;

    seq_frame_tx #(.GAP_CYCLES(1)) dut_a (
        .clk(clk), .reset(rst_n), .in_valid(a_valid), .in_data(a_data),
        .in_ready(a_ready), .x(a_x), .x_valid(a_xv), .busy(a_busy), .done(a_done)
    );

    seq_frame_tx #(.GAP_CYCLES(0)) dut_b (
        .clk(clk), .reset(rst_n), .in_valid(b_valid), .in_data(b_data),
        .in_ready(b_ready), .x(b_x), .x_valid(b_xv), .busy(b_busy), .done(b_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s t=%0t observed=%0h expected=%0h", tag, $time, obs, exp);
        end
    endtask

    // Frame as it should appear on x: preamble 1011, payload MSB first, optional parity.
    function automatic logic [FL-1:0] exp_frame(input logic [7:0] d);
`ifdef PARITY_EN
        return {4'b1011, d, ^d};
`else
        return {4'b1011, d};
`endif
    endfunction

    // Full frame on instance A, with optional in_valid/in_data disturbance mid-payload.
    // Also runs a reference 1011 overlapping detector on x and logs hit positions.
    task automatic send_a(input logic [7:0] d, input bit disturb);
        logic [FL-1:0] f;
        logic [3:0] hist;
        f = exp_frame(d);
        hist = 4'b0000;
        chk("a_ready_before_accept", a_ready, 1);
        a_valid = 1'b1;
        a_data  = d;
        @(posedge clk);
        #1 a_valid = 1'b0;
        for (int i = 0; i < FL; i++) begin
            @(negedge clk);
            chk($sformatf("a_x[%0d] d=%0h", i, d), a_x, f[FL-1-i]);
            chk($sformatf("a_xv[%0d]", i), a_xv, 1);
            chk($sformatf("a_done[%0d]", i), a_done, (i == FL-1));
            chk($sformatf("a_ready[%0d]", i), a_ready, 0);
            chk($sformatf("a_busy[%0d]", i), a_busy, 1);
            hist = {hist[2:0], a_x};
            if (i >= 3 && hist == 4'b1011) z_pos.push_back(i);
            if (disturb && i == PRE_W + 2) begin a_valid = 1'b1; a_data = ~d; end
            if (disturb && i == PRE_W + 4) begin a_valid = 1'b0; a_data = d;  end
        end
        @(negedge clk);
        chk("a_gap_xv", a_xv, 0);
        chk("a_gap_busy", a_busy, 1);
        chk("a_gap_ready", a_ready, 0);
        chk("a_gap_done", a_done, 0);
        @(negedge clk);
        chk("a_idle_ready", a_ready, 1);
        chk("a_idle_busy", a_busy, 0);
        chk("a_idle_xv", a_xv, 0);
    endtask

    initial begin
        logic [FL-1:0] fb;

        // Reset state, with in_valid held high during reset.
        a_valid = 1'b1;
        a_data  = 8'h5A;
        repeat (3) @(negedge clk);
        chk("rst_x", a_x, 0);
        chk("rst_xv", a_xv, 0);
        chk("rst_done", a_done, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_ready", a_ready, 1);
        chk("rst_b_busy", b_busy, 0);
        chk("rst_b_ready", b_ready, 1);

        // Test 1: A5 accepted at the first edge after release.
        a_data = 8'hA5;
        rst_n  = 1'b1;
        $display("step: frame A5 after reset");
        send_a(8'hA5, 1'b0);

        // Test 3: in_valid/in_data toggled during the payload must not matter.
        $display("step: frame 6E with mid-frame disturbance");
        send_a(8'h6E, 1'b1);
        repeat (2) begin
            @(negedge clk);
            chk("no_extra_frame_xv", a_xv, 0);
            chk("no_extra_frame_busy", a_busy, 0);
        end

        // Test 4: asynchronous reset during the 3rd payload bit.
        $display("step: reset during payload bit 3");
        a_valid = 1'b1;
        a_data  = 8'hFF;
        @(posedge clk);
        #1 a_valid = 1'b0;
        repeat (PRE_W + 3) @(negedge clk);
        chk("mid_x_before_reset", a_x, 1);
        chk("mid_busy_before_reset", a_busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_x", a_x, 0);
        chk("async_rst_xv", a_xv, 0);
        chk("async_rst_busy", a_busy, 0);
        chk("async_rst_ready", a_ready, 1);
        chk("async_rst_done", a_done, 0);
        repeat (2) begin
            @(negedge clk);
            chk("in_rst_done", a_done, 0);
            chk("in_rst_xv", a_xv, 0);
        end
        rst_n = 1'b1;
        $display("step: frame 3C after reset");
        send_a(8'h3C, 1'b0);

        // Test 5: parity values (plain frames without PARITY_EN).
        $display("step: frames 07 and 03");
        send_a(8'h07, 1'b0);
        send_a(8'h03, 1'b0);

        // Test 6: 1011 detector hits at preamble bit 4 and payload bits 4 and 7.
        $display("step: frame B6 into 1011 detector");
        z_pos.delete();
        send_a(8'hB6, 1'b0);
        chk("det_hits", z_pos.size(), 3);
        chk("det_hit0", z_pos[0], 3);
        chk("det_hit1", z_pos[1], 7);
        chk("det_hit2", z_pos[2], 10);

        // Test 2: back-to-back frames with no gap, in_valid held high.
        $display("step: back-to-back FF then 00, no gap");
        b_valid = 1'b1;
        b_data  = 8'hFF;
        @(posedge clk);
        #1 b_data = 8'h00;
        fb = exp_frame(8'hFF);
        for (int i = 0; i < FL; i++) begin
            @(negedge clk);
            chk($sformatf("b1_x[%0d]", i), b_x, fb[FL-1-i]);
            chk($sformatf("b1_xv[%0d]", i), b_xv, 1);
            chk($sformatf("b1_done[%0d]", i), b_done, (i == FL-1));
            chk($sformatf("b1_ready[%0d]", i), b_ready, 0);
        end
        @(negedge clk);
        chk("b_bubble_xv", b_xv, 0);
        chk("b_bubble_ready", b_ready, 1);
        chk("b_bubble_busy", b_busy, 0);
        chk("b_bubble_done", b_done, 0);
        @(posedge clk);
        #1 b_valid = 1'b0;
        fb = exp_frame(8'h00);
        for (int i = 0; i < FL; i++) begin
            @(negedge clk);
            chk($sformatf("b2_x[%0d]", i), b_x, fb[FL-1-i]);
            chk($sformatf("b2_xv[%0d]", i), b_xv, 1);
            chk($sformatf("b2_done[%0d]", i), b_done, (i == FL-1));
        end
        @(negedge clk);
        chk("b_end_xv", b_xv, 0);
        chk("b_end_ready", b_ready, 1);
        @(negedge clk);
        chk("b_no_third_xv", b_xv, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
